// File: rtl/axi4_master_bridge.sv
`default_nettype none
// =============================================================================
// axi4_master_bridge : single-outstanding core request -> AXI4 master bridge.
// Optional watchdog enabled by defining AXI4_MASTER_BRIDGE_TIMEOUT_EN.
// Revision: 1.0
// =============================================================================
module axi4_master_bridge #(
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [7:0]  req_len,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_last,
    output logic        rsp_err,
    output logic        io_master_awvalid,
    input  logic        io_master_awready,
    output logic [3:0]  io_master_awid,
    output logic [31:0] io_master_awaddr,
    output logic [7:0]  io_master_awlen,
    output logic [2:0]  io_master_awsize,
    output logic [1:0]  io_master_awburst,
    output logic        io_master_wvalid,
    input  logic        io_master_wready,
    output logic [31:0] io_master_wdata,
    output logic [3:0]  io_master_wstrb,
    output logic        io_master_wlast,
    input  logic        io_master_bvalid,
    output logic        io_master_bready,
    input  logic [3:0]  io_master_bid,
    input  logic [1:0]  io_master_bresp,
    output logic        io_master_arvalid,
    input  logic        io_master_arready,
    output logic [3:0]  io_master_arid,
    output logic [31:0] io_master_araddr,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    input  logic        io_master_rvalid,
    output logic        io_master_rready,
    input  logic [3:0]  io_master_rid,
    input  logic [31:0] io_master_rdata,
    input  logic [1:0]  io_master_rresp,
    input  logic        io_master_rlast
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WREQ  = 3'd3,
        S_WRESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_last_q, rsp_last_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic r_final;
    logic wdog_fire;
    logic unused_ids;

    // Response IDs carry no information with a single outstanding transaction.
    assign unused_ids = ^{io_master_rid, io_master_bid};

    assign req_ready         = (state_q == S_IDLE) && !reset;
    assign io_master_awvalid = (state_q == S_WREQ) && !aw_done_q;
    assign io_master_wvalid  = (state_q == S_WREQ) && !w_done_q;
    assign io_master_bready  = (state_q == S_WRESP);
    assign io_master_arvalid = (state_q == S_RADDR);
    assign io_master_rready  = (state_q == S_RDATA);

    assign io_master_awid    = AXI_ID;
    assign io_master_awaddr  = addr_q;
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = 3'b010;
    assign io_master_awburst = 2'b01;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = 1'b1;
    assign io_master_arid    = AXI_ID;
    assign io_master_araddr  = addr_q;
    assign io_master_arlen   = len_q;
    assign io_master_arsize  = 3'b010;
    assign io_master_arburst = 2'b01;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;

    assign aw_hs = io_master_awvalid && io_master_awready;
    assign w_hs  = io_master_wvalid  && io_master_wready;
    assign b_hs  = io_master_bready  && io_master_bvalid;
    assign ar_hs = io_master_arvalid && io_master_arready;
    assign r_hs  = io_master_rready  && io_master_rvalid;

`ifdef AXI4_MASTER_BRIDGE_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;
    logic       any_hs;

    assign any_hs    = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    // Fires on the edge where the counter would reach 255.
    assign wdog_fire = (state_q != S_IDLE) && !any_hs && (wdog_q == 8'd254);

    always_comb begin
        wdog_d = 8'd0;
        if ((state_q != S_IDLE) && !any_hs) begin
            wdog_d = wdog_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wdog_q <= 8'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        len_d       = len_q;
        beat_d      = beat_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        r_final     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    len_d     = req_len;
                    beat_d    = 8'd0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_wen ? S_WREQ : S_RADDR;
                end
            end
            S_RADDR: begin
                if (ar_hs) begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (r_hs) begin
                    // A beat-count/rlast disagreement ends the burst as an error.
                    r_final     = io_master_rlast || (beat_q == len_q);
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = io_master_rdata;
                    rsp_last_d  = r_final;
                    rsp_err_d   = (io_master_rresp != 2'b00)
                                || (io_master_rlast && (beat_q < len_q))
                                || ((beat_q == len_q) && !io_master_rlast);
                    beat_d      = beat_q + 8'd1;
                    if (r_final) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WREQ: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q  || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (b_hs) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = (io_master_bresp != 2'b00);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wdog_fire) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            rsp_last_d  = 1'b1;
            rsp_err_d   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            len_q       <= 8'd0;
            beat_q      <= 8'd0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/axi4_master_bridge.md
AXI4_MASTER_BRIDGE -- requirements
Module: axi4_master_bridge

Interface
REQ-001 Parameter AXI_ID, default 4'h0, constant driven on io_master_awid and io_master_arid.
REQ-002 clock  input  1  sole clock, rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid / req_ready  input / output  1 / 1  core-side request handshake.
REQ-005 req_wen  input  1  1 = write, 0 = read.
REQ-006 req_addr / req_wdata  input  32 / 32  byte address; write data.
REQ-007 req_wstrb  input  4  write byte strobes.
REQ-008 req_len  input  8  read burst beats minus one; ignored for writes.
REQ-009 rsp_valid  output  1  one-cycle pulse per read beat or per write completion.
REQ-010 rsp_rdata / rsp_last / rsp_err  output  32 / 1 / 1  read data; final beat or write done; non-OKAY response or timeout.
REQ-011 io_master_aw*: valid out 1, ready in 1, id out 4, addr out 32, len out 8, size out 3, burst out 2.
REQ-012 io_master_w*: valid out 1, ready in 1, data out 32, strb out 4, last out 1.
REQ-013 io_master_b*: valid in 1, ready out 1, id in 4, resp in 2.
REQ-014 io_master_ar*: valid out 1, ready in 1, id out 4, addr out 32, len out 8, size out 3, burst out 2.
REQ-015 io_master_r*: valid in 1, ready out 1, id in 4, data in 32, resp in 2, last in 1.

Function
REQ-016 FSM states: IDLE, RADDR, RDATA, WREQ, WRESP; at most one transaction outstanding.
REQ-017 req_ready = (state == IDLE); on req_valid && req_ready, latch addr, wdata, wstrb, len and wen.
REQ-018 Read accept: IDLE->RADDR; arvalid = 1 from next cycle; araddr = latched addr; arlen = latched len; arsize = 3'b010; arburst = 2'b01 (INCR). All held stable until arready.
REQ-019 RADDR->RDATA on arvalid && arready, which also drops arvalid; rready = 1 only in RDATA.
REQ-020 Each R handshake: next cycle rsp_valid = 1, rsp_rdata = rdata, rsp_last = rlast; 8-bit beat counter increments.
REQ-021 rsp_err on a beat = (rresp != 2'b00), OR rlast arrives while count < len, OR count == len without rlast.
REQ-022 RDATA->IDLE on a handshake with rlast = 1 or count == len; rsp_last is forced to 1 on that beat.
REQ-023 Write accept: IDLE->WREQ; awvalid and wvalid both 1 next cycle; awlen = 0; awsize = 3'b010; awburst = INCR; wlast = 1; wdata and wstrb latched.
REQ-024 awvalid and wvalid each drop on their own handshake, in either order or the same cycle; WREQ->WRESP once both are done.
REQ-025 bready = 1 only in WRESP; on bvalid go to IDLE; next cycle rsp_valid = 1, rsp_last = 1, rsp_err = (bresp != 2'b00), rsp_rdata holds its previous value.
REQ-026 rid and bid are ignored.
REQ-027 A new request is accepted in the cycle the final rsp_valid pulses; no bubble is added.
REQ-028 With ready/valid returned immediately, rsp_valid occurs exactly 3 cycles after request acceptance, for both a single-beat read and a write.

Reset
REQ-029 During reset: state = IDLE; all AXI valid and ready outputs = 0; req_ready = 0; rsp_valid, rsp_last and rsp_err = 0; rsp_rdata = 0; beat counter = 0.
REQ-030 Reset mid-transaction abandons the transaction: no response pulse, and valids drop at the reset edge.

Configuration
REQ-031 Macro AXI4_MASTER_BRIDGE_TIMEOUT_EN defined: an 8-bit watchdog increments in every non-IDLE cycle without an AXI handshake and clears on any handshake or in IDLE.
REQ-032 On reaching 255 the watchdog drops all valids and readies, returns to IDLE, and pulses rsp_valid with rsp_err = 1 and rsp_last = 1.
REQ-033 Macro undefined: no watchdog logic is present, and the bridge waits indefinitely.

Verification
REQ-034 Read addr 0x8000_0000, len 0, arready and rvalid immediate, rdata 0x1234_5678 -> arlen 0; one rsp pulse 3 cycles after accept with rdata 0x1234_5678, last = 1, err = 0.
REQ-035 Read len 3 with rvalid gaps, rlast on beat 3 -> 4 rsp pulses in order; last only on beat 3; araddr and arlen stable while arready is held low for 5 cycles.
REQ-036 Write 0x8000_0010, data 0xDEAD_BEEF, strb 4'b0011, wready 2 cycles after awready -> awvalid drops first; one rsp pulse with last = 1 after bvalid; strb 4'b0011 seen on the bus.
REQ-037 bresp = 2'b10 on a write, and rresp = 2'b11 on a read beat -> rsp_err = 1 on the corresponding pulse.
REQ-038 Reset asserted in RDATA after beat 1 of 4 -> no further rsp pulses; req_ready returns 1 on the first cycle after reset deasserts.
REQ-039 With AXI4_MASTER_BRIDGE_TIMEOUT_EN defined and arready stuck at 0 -> arvalid drops; rsp_valid with err = 1 occurs 255 cycles after arvalid first rises.
